serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial subtractor. Computes diff = a - b - bin over WIDTH operand bits.
- Processes one bit per clock, LSB first, through a single full-subtractor cell.
- Counterpart to the team's parallel ripple adder. Used where area matters more than latency; shares the same a/b/carry-style operand interface.
- Uses a start/busy/done handshake. Results are held stable until the next accepted start.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE; operands are latched on the same edge.
- a  input  WIDTH  minuend. Sampled only with an accepted start.
- b  input  WIDTH  subtrahend. Sampled only with an accepted start.
- bin  input  1  borrow-in. Sampled only with an accepted start.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- diff  output  WIDTH  difference, registered.
- bout  output  1  borrow-out (unsigned underflow), registered.
- overflow  output  1  two's-complement overflow flag, registered.

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (rst).
- Reset: rst=1 forces, asynchronously, state=IDLE, counter=0, all internal shift registers and borrow FF =0, and outputs busy=0, done=0, diff=0, bout=0, overflow=0.
- Reset mid-operation aborts the operation. No done is produced, and outputs return to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch a into ra, b into rb, bin into the borrow FF; clear the bit counter; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), on each edge:
  - Bit cell: d = ra[0]^rb[0]^brw; brw_next = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&brw).
  - Shift ra and rb right by one. Shift d into the MSB of the working register wd (right shift).
  - Update the borrow FF; increment the counter.
  - When the counter equals WIDTH-1 on this edge (the last bit is processed):
    - Load diff with the final wd value (including this edge's d).
    - Load bout with brw_next.
    - Load overflow with (a_msb != b_msb) && (diff_msb != a_msb), using the originally latched operand MSBs (held in a separate 2-bit register).
    - Go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then go to IDLE on the next edge.
  - start is ignored in DONE.
- Latency: start sampled at edge 0; bits processed at edges 1..WIDTH; done high in the cycle after edge WIDTH; IDLE again after edge WIDTH+1. Earliest next accept is at edge WIDTH+2.
- Input rules:
  - start is ignored whenever busy=1.
  - a, b and bin may change freely after the accepting edge with no effect.
- Result stability:
  - diff, bout and overflow change only on the final SHIFT edge or on reset.
  - They hold their previous result during the next computation until its final edge.
- Arithmetic: modulo 2^WIDTH.
  - bout=1 iff a < b + bin (unsigned).
  - overflow per signed interpretation of a, b and diff.
- Counter width is clog2(WIDTH). Wrap-around cannot occur because the counter is cleared on every accept.

Decomposition:
- Shared package/include, containing:
  - state encodings: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10, with 2'b11 decoding to IDLE;
  - the state width constant;
  - a clog2 helper function for the counter width.
- One sub-module, full_subtractor: combinational; inputs x, y, bi; outputs d, bo. Instantiated once as the bit cell.
- Everything else lives in serial_subtractor.

Test Plan:
- Reset, then a=1010 b=0110 bin=0, start pulse:
  - busy rises after edge 0; done pulses in the cycle after edge 4;
  - diff=0100, bout=0, overflow=1.
- a=0110 b=1010 bin=0 → diff=1100, bout=1, overflow=1.
- a=0000 b=0000 bin=1 → diff=1111, bout=1, overflow=0.
- a=1111 b=1111 bin=0 → diff=0000, bout=0, overflow=0.
- Hold start=1 continuously with a=1010 b=1010 bin=1:
  - start pulses during SHIFT/DONE are ignored; the operands are not re-latched mid-operation;
  - diff=1111, bout=1, overflow=0, done once;
  - the next accept occurs exactly at edge 6 and done then repeats every 6 cycles;
  - diff holds its prior value until each final edge.
- Assert rst at the 2nd SHIFT cycle of a=0110 b=0001:
  - all outputs 0 immediately (asynchronous), no done pulse;
  - after release, a fresh start with a=0110 b=0001 bin=0 → diff=0101, bout=0, overflow=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and a
// constant clog2 helper used to size the bit counter.
package serial_subtractor_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'b01;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'b10;

  function automatic int clog2_fn(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a start/busy/done handshake and results held until the next result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CNT_W = clog2_fn(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [WIDTH-1:0]   wd_q, wd_d;
  logic               brw_q, brw_d;
  logic [1:0]         msb_q, msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] wd_shift;

  full_subtractor u_cell (
    .x  (ra_q[0]),
    .y  (rb_q[0]),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign wd_shift = {cell_d, wd_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    wd_d    = wd_q;
    brw_d   = brw_q;
    msb_d   = msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_SHIFT: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        wd_d  = wd_shift;
        brw_d = cell_bo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = wd_shift;
          bout_d  = cell_bo;
          // msb_q = {a_msb, b_msb} captured at accept time
          ovf_d   = (msb_q[1] != msb_q[0]) && (wd_shift[WIDTH-1] != msb_q[1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // 2'b11 is treated as IDLE so a corrupted state recovers.
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          brw_d   = bin;
          msb_d   = {a[WIDTH-1], b[WIDTH-1]};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      wd_q    <= '0;
      brw_q   <= 1'b0;
      msb_q   <= 2'b00;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      wd_q    <= wd_d;
      brw_q   <= brw_d;
      msb_q   <= msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus queues hand-computed
// results, a negedge monitor pops and compares them whenever done pulses.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  // Expected result packed as {diff, bout, overflow}.
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] mon_exp;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("result diff=%b bout=%b overflow=%b (expect %b %b %b)",
                 diff, bout, overflow, mon_exp[WIDTH+1:2], mon_exp[1], mon_exp[0]);
        check("diff", 32'(diff), 32'(mon_exp[WIDTH+1:2]));
        check("bout", 32'(bout), 32'(mon_exp[1]));
        check("overflow", 32'(overflow), 32'(mon_exp[0]));
      end
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tbin, input logic [WIDTH+1:0] exp);
    int seen;
    seen = -1;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    exp_q.push_back(exp);
    for (int k = 0; k < 3 * WIDTH && seen < 0; k++) begin
      @(negedge clk);
      // Operands are scrambled after the accept; they must have no effect.
      start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
      if (k == 0) check("busy_after_accept", 32'(busy), 32'd1);
      if (done) seen = k;
    end
    check("done_latency", 32'(seen), 32'(WIDTH));
    @(negedge clk);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int first_done, second_done, ndone, dc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'b1010, 4'b0110, 1'b0, {4'b0100, 1'b0, 1'b1});
    run_op(4'b0110, 4'b1010, 1'b0, {4'b1100, 1'b1, 1'b1});

    // Abort in the second SHIFT cycle; outputs must clear asynchronously.
    @(negedge clk);
    a = 4'b0110; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    dc = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt), 32'(dc));
    check("idle_after_abort", 32'(busy), 32'd0);

    run_op(4'b0110, 4'b0001, 1'b0, {4'b0101, 1'b0, 1'b0});
    run_op(4'b0000, 4'b0000, 1'b1, {4'b1111, 1'b1, 1'b0});
    run_op(4'b1111, 4'b1111, 1'b0, {4'b0000, 1'b0, 1'b0});

    // start held high: accepts at edges 0 and 6, done at n_4 and n_10.
    first_done = -1; second_done = -1; ndone = 0;
    @(negedge clk);
    a = 4'b1010; b = 4'b1010; bin = 1'b1; start = 1'b1;
    exp_q.push_back({4'b1111, 1'b1, 1'b0});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
        else second_done = k;
      end
      if (k == 2) check("diff_hold_first", 32'(diff), 32'(4'b0000));
      if (k == 3) begin
        a = 4'b0011; b = 4'b0001; bin = 1'b0;
        exp_q.push_back({4'b0010, 1'b0, 1'b0});
      end
      if (k == 8) check("diff_hold_second", 32'(diff), 32'(4'b1111));
      if (k == 10) start = 1'b0;
    end
    check("held_first_done", 32'(first_done), 32'd4);
    check("held_second_done", 32'(second_done), 32'd10);
    check("held_done_count", 32'(ndone), 32'd2);
    check("held_idle_after", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
